// File: rtl/oled_digit_column_streamer_pkg.sv
// Shared display types: 7-segment code, page count, glyph index widths, sequencer states.
// No logic; compile-time definitions only.
// No flow control; consumers apply their own.
package oled_digit_column_streamer_pkg;

    localparam int PAGES     = 4;
    localparam int GLYPH_X_W = 4;
    localparam int GLYPH_Y_W = 2;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
    } seg_bits_t;

    // Named-segment view and raw 7-bit view of the same code.
    typedef union packed {
        seg_bits_t  seg;
        logic [6:0] individual;
    } Segments;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/oled_digit_column_streamer_scan_index_counter.sv
// Nested col/digit/page scan counter with enable, synchronous clear and final-index flag.
// Latency: indices update one cycle after en; last is combinational from current indices.
// No backpressure of its own; caller gates en.
module oled_digit_column_streamer_scan_index_counter
    import oled_digit_column_streamer_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CHAR_W     = 16,
    localparam int DIGIT_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 en,
    output logic [GLYPH_X_W-1:0] col,
    output logic [DIGIT_W-1:0]   digit,
    output logic [GLYPH_Y_W-1:0] page,
    output logic                 last
);

    localparam logic [GLYPH_X_W-1:0] COL_LAST   = GLYPH_X_W'(CHAR_W - 1);
    localparam logic [DIGIT_W-1:0]   DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);
    localparam logic [GLYPH_Y_W-1:0] PAGE_LAST  = GLYPH_Y_W'(PAGES - 1);

    logic col_wrap;
    logic digit_wrap;

    assign col_wrap   = (col == COL_LAST);
    assign digit_wrap = (digit == DIGIT_LAST);
    assign last       = col_wrap && digit_wrap && (page == PAGE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            digit <= '0;
            page  <= '0;
        end else if (clear) begin
            col   <= '0;
            digit <= '0;
            page  <= '0;
        end else if (en) begin
            col <= col_wrap ? '0 : col + 1'b1;
            if (col_wrap) begin
                digit <= digit_wrap ? '0 : digit + 1'b1;
                // Page wraps to 0 after the final index, leaving the scan ready for the next frame.
                if (digit_wrap) begin
                    page <= (page == PAGE_LAST) ? '0 : page + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/oled_digit_column_streamer.sv
// Scans page/digit/column over latched 7-seg codes and streams decoded pixel columns to the OLED.
// Latency: first byte valid two cycles after start; one byte per cycle while byte_ready holds.
// Backpressure: byte_valid && !byte_ready freezes byte_data/byte_valid and the scan indices.
module oled_digit_column_streamer
    import oled_digit_column_streamer_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CHAR_W     = 16,
    localparam int DIGIT_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  Segments              digits_in [NUM_DIGITS],
    output logic                 busy,
    output logic                 done,
    output Segments              glyph_segments,
    output logic [GLYPH_X_W-1:0] glyph_x,
    output logic [GLYPH_Y_W-1:0] glyph_y,
    input  logic [7:0]           glyph_column,
    output logic [7:0]           byte_data,
    output logic                 byte_valid,
    input  logic                 byte_ready
);

    state_t              state;
    state_t              state_nxt;
    Segments             latched [NUM_DIGITS];
    logic [DIGIT_W-1:0]  digit;
    logic                last;
    logic                adv;
    logic                cnt_clear;
    logic                latch_en;
    logic                drain_hs;

    oled_digit_column_streamer_scan_index_counter #(
        .NUM_DIGITS (NUM_DIGITS),
        .CHAR_W     (CHAR_W)
    ) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .en    (adv),
        .col   (glyph_x),
        .digit (digit),
        .page  (glyph_y),
        .last  (last)
    );

    assign glyph_segments = latched[digit];
    assign busy           = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        adv       = 1'b0;
        cnt_clear = 1'b0;
        latch_en  = 1'b0;
        drain_hs  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    cnt_clear = 1'b1;
                    latch_en  = 1'b1;
                end
            end
            ST_RUN: begin
                // Any handshake in RUN is also an advance, so the output slot never empties mid-frame.
                if (!byte_valid || byte_ready) begin
                    adv = 1'b1;
                    if (last) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (byte_valid && byte_ready) begin
                    state_nxt = ST_IDLE;
                    drain_hs  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_data  <= '0;
            byte_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= drain_hs;
            if (adv) begin
                byte_data  <= glyph_column;
                byte_valid <= 1'b1;
            end else if (drain_hs) begin
                byte_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                latched[i] <= '0;
            end
        end else if (latch_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                latched[i] <= digits_in[i];
            end
        end
    end

endmodule

// File: doc/oled_digit_column_streamer.md
# oled_digit_column_streamer

Sequencer that turns a latched row of 7-segment digit codes into the linear byte stream an SSD1306 expects in horizontal addressing mode. It scans page, digit and column indices, drives the combinational glyph column decoder through a request port, registers each returned 8-pixel column and offers it on a valid/ready byte stream. It sits between the frequency-counter display formatter (upstream) and the OLED data-phase serialiser (downstream).

## Interface
- NUM_DIGITS, 4, number of character cells per frame (≥1)
- CHAR_W, 16, columns per character cell (1..16, fits glyph_x)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  frame request pulse; sampled only in IDLE
- digits_in  in  Segments[NUM_DIGITS]  segment codes, index 0 = leftmost; captured on accepted start
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse after the last byte handshake
- glyph_segments  out  Segments  code of the digit currently scanned
- glyph_x  out  4  column within cell, 0..CHAR_W-1
- glyph_y  out  2  page, 0..3
- glyph_column  in  8  decoder result for current request (combinational, same cycle)
- byte_data  out  8  pixel column, bit 0 = top row of page
- byte_valid  out  1  byte_data valid
- byte_ready  in  1  downstream accepts byte

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 → latch digits_in, clear counters (page=0, digit=0, col=0), go RUN. start ignored outside IDLE.
- Scan order: page outer (0..3), digit middle (0..NUM_DIGITS-1), col inner (0..CHAR_W-1). Total bytes = 4·NUM_DIGITS·CHAR_W (256 default).
- glyph_segments = latched[digit], glyph_x = col, glyph_y = page; glyph_* held stable whenever no advance occurs.
- Advance condition adv = state==RUN && (!byte_valid || byte_ready). On adv: byte_data ← glyph_column, byte_valid ← 1, counters step; if counters were at the final index (page 3, digit N-1, col CHAR_W-1) go DRAIN.
- Non-advancing handshake in RUN impossible (adv covers it); in DRAIN, byte_ready && byte_valid → byte_valid ← 0, done ← 1, go IDLE.
- byte_data and byte_valid must not change while byte_valid && !byte_ready.
- Counter wrap: col CHAR_W-1→0 increments digit; digit N-1→0 increments page; widths: digit counter max(1,$clog2(NUM_DIGITS)).
- Latched digits are immune to digits_in changes during a frame.

## Timing
- Reset (async assert, sync release): state IDLE, busy 0, done 0, byte_valid 0, byte_data 0, counters 0, latched digits 0, glyph_* 0.
- start accepted in cycle T: busy=1 from T+1; first request presented T+1; first byte_valid T+2.
- byte_ready held 1: one byte per cycle, last byte valid T+1+B (B = total bytes), done=1 and busy=0 at T+2+B; next start accepted from that cycle.
- busy = state != IDLE; done is registered, single cycle.
- Reset mid-frame: frame abandoned, no done; next start produces a full frame from (0,0,0).

## Structure
- Shared display package: Segments typedef (packed struct a..g with .individual view), PAGES=4 constant, glyph index widths.
- One natural sub-module: scan_index_counter (nested col/digit/page counter with enable, clear and last flag); FSM and output register stay in the top.
- Glyph decoder instanced beside this block by the integrator, not inside it.

## Test plan
- Defaults, all digits 7'h7F, byte_ready=1, start at T → first byte_valid T+2, exactly 256 handshakes, done pulse T+258, busy low same cycle.
- Stub decoder returning {glyph_y, glyph_x, 2'b00}, NUM_DIGITS=4 → byte k equals {k/64, k%16, 2'b00}; order matches page/digit/col scan.
- byte_ready toggled 1/0 every cycle and random stalls → byte_data/valid stable during stall, 256 bytes, no loss or duplication, done after last handshake.
- start pulsed while busy and digits_in changed mid-frame → ignored; glyph_segments reflects only values latched at T.
- rst_n low at byte 100 → byte_valid/busy 0 immediately, no done; restart gives full 256-byte frame from page 0 col 0.
- NUM_DIGITS=1, CHAR_W=8 → 32 bytes, glyph_x wraps 7→0 with page increment, done at T+34.
